// File: rtl/rca_seq_arbiter.sv
// rca_seq_arbiter
//   Two-requester round-robin front end for a shared 4-bit ripple-carry slice.
//   Each accepted operand pair is added one nibble per cycle, LSB first,
//   over NIB = WIDTH/4 passes. The result is presented with a valid/ready
//   handshake.
//
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req0_valid/ready/a/b  requester 0 operand handshake
//   req1_valid/ready/a/b  requester 1 operand handshake
//   res_valid/ready       result handshake
//   res_sum               WIDTH+1 bit unsigned sum (MSB = final carry)
//   res_id                requester that owns res_sum
//   busy                  high while an add is in flight or its result is pending
module rca_seq_arbiter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH:0]   res_sum,
    output logic             res_id,
    output logic             busy
);

    localparam int unsigned NIB = WIDTH / 4;
    localparam int unsigned CW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t           state;
    logic             ptr;      // requester favoured when both are valid
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] acc;      // sum nibbles, filled from the top

    logic             grant0;
    logic             grant1;
    logic [4:0]       c;
    logic [3:0]       slice_sum;
    logic             slice_cout;
    logic [WIDTH-1:0] next_acc;

    always_comb begin
        grant0 = req0_valid && (!req1_valid || !ptr);
        grant1 = req1_valid && (!req0_valid || ptr);
    end

    // Readies are gated by rst_n so they drop immediately on reset assertion.
    always_comb begin
        req0_ready = rst_n && (state == IDLE) && grant0;
        req1_ready = rst_n && (state == IDLE) && grant1;
    end

    // 4-bit ripple of full adders; bit-0 carry-in comes from the carry register.
    always_comb begin
        c         = '0;
        slice_sum = '0;
        c[0]      = carry;
        for (int unsigned i = 0; i < 4; i++) begin
            slice_sum[i] = op_a[i] ^ op_b[i] ^ c[i];
            c[i+1]       = (op_a[i] & op_b[i]) | (c[i] & (op_a[i] ^ op_b[i]));
        end
        slice_cout = c[4];
    end

    // New nibble enters at the top; concatenate-then-shift keeps WIDTH == 4 legal.
    always_comb begin
        next_acc = WIDTH'({slice_sum, acc} >> 4);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_id    <= 1'b0;
            busy      <= 1'b0;
            ptr       <= 1'b0;
            carry     <= 1'b0;
            cnt       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            acc       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        op_a   <= grant1 ? req1_a : req0_a;
                        op_b   <= grant1 ? req1_b : req0_b;
                        res_id <= grant1;
                        ptr    <= ~grant1;
                        carry  <= 1'b0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= ADD;
                    end
                end
                ADD: begin
                    op_a  <= op_a >> 4;
                    op_b  <= op_b >> 4;
                    acc   <= next_acc;
                    carry <= slice_cout;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(NIB - 1)) begin
                        res_sum   <= {slice_cout, next_acc};
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rca_seq_arbiter.sv
// Testbench for rca_seq_arbiter: directed vector table, hand-written corner
// sequences and randomized traffic, all checked every cycle against a
// transaction-level reference model.
module tb_rca_seq_arbiter;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req0_valid = 1'b0;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a = '0;
    logic [WIDTH-1:0] req0_b = '0;
    logic             req1_valid = 1'b0;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a = '0;
    logic [WIDTH-1:0] req1_b = '0;
    logic             res_valid;
    logic             res_ready = 1'b1;
    logic [WIDTH:0]   res_sum;
    logic             res_id;
    logic             busy;

    always #5 clk = ~clk;

    rca_seq_arbiter #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_sum    (res_sum),
        .res_id     (res_id),
        .busy       (busy)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: idle flag, remaining slice passes, pending result.
    logic           m_idle;
    logic           m_done;
    int             m_wait;
    logic           m_ptr;
    logic [WIDTH:0] m_sum;
    logic           m_id;

    function automatic logic m_grant(input logic id);
        logic mine, other;
        mine  = id ? req1_valid : req0_valid;
        other = id ? req0_valid : req1_valid;
        return mine && (!other || (m_ptr == id));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_idle <= 1'b1;
            m_done <= 1'b0;
            m_wait <= 0;
            m_ptr  <= 1'b0;
            m_sum  <= '0;
            m_id   <= 1'b0;
        end else if (m_idle) begin
            if (m_grant(1'b0) || m_grant(1'b1)) begin
                m_id   <= m_grant(1'b1);
                m_ptr  <= !m_grant(1'b1);
                m_sum  <= m_grant(1'b1) ? ({1'b0, req1_a} + {1'b0, req1_b})
                                        : ({1'b0, req0_a} + {1'b0, req0_b});
                m_idle <= 1'b0;
                m_wait <= NIB;
            end
        end else if (m_wait > 0) begin
            m_wait <= m_wait - 1;
            if (m_wait == 1) m_done <= 1'b1;
        end else if (res_ready) begin
            m_done <= 1'b0;
            m_idle <= 1'b1;
        end
    end

    logic           s_r0, s_r1, s_rv, s_id, s_busy;
    logic [WIDTH:0] s_sum;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: sample and check at the falling edge, return just after the rising edge.
    task automatic cycle();
        @(negedge clk);
        s_r0   = req0_ready;
        s_r1   = req1_ready;
        s_rv   = res_valid;
        s_sum  = res_sum;
        s_id   = res_id;
        s_busy = busy;
        chk("req0_ready", 32'(s_r0), 32'(rst_n && m_idle && m_grant(1'b0)));
        chk("req1_ready", 32'(s_r1), 32'(rst_n && m_idle && m_grant(1'b1)));
        chk("res_valid", 32'(s_rv), 32'(m_done));
        chk("busy", 32'(s_busy), 32'(!m_idle));
        if (m_done) begin
            chk("res_sum", 32'(s_sum), 32'(m_sum));
            chk("res_id", 32'(s_id), 32'(m_id));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_accept(input logic id);
        logic got;
        got = 1'b0;
        for (int k = 0; k < 30 && !got; k++) begin
            cycle();
            got = id ? s_r1 : s_r0;
        end
        if (!got) chk("accept_timeout", 32'(got), 32'd1);
        if (id) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic wait_result(input string name, input logic id, input logic [WIDTH:0] sum);
        logic got;
        got = 1'b0;
        for (int k = 0; k < 30 && !got; k++) begin
            cycle();
            got = s_rv;
        end
        chk({name, "_seen"}, 32'(got), 32'd1);
        chk({name, "_sum"}, 32'(s_sum), 32'(sum));
        chk({name, "_id"}, 32'(s_id), 32'(id));
    endtask

    typedef struct {
        logic           id;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH:0] sum;
    } vec_t;

    vec_t tv[6];

    initial begin
        logic           got;
        int             lat;
        logic [WIDTH:0] held;

        tv[0] = '{1'b0, 16'hFFFF, 16'h0001, 17'h10000};
        tv[1] = '{1'b1, 16'hFFFF, 16'hFFFF, 17'h1FFFE};
        tv[2] = '{1'b0, 16'h0000, 16'h0000, 17'h00000};
        tv[3] = '{1'b1, 16'h8000, 16'h8000, 17'h10000};
        tv[4] = '{1'b0, 16'hABCD, 16'h1234, 17'h0BE01};
        tv[5] = '{1'b1, 16'h0FFF, 16'h0001, 17'h01000};

        // Both requesters valid from reset; readies must stay low while in reset.
        req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 16'h1111;
        req1_valid = 1'b1; req1_a = 16'h0F0F; req1_b = 16'h00F1;
        cycle();
        cycle();
        chk("rst_req0_ready", 32'(s_r0), 32'd0);
        chk("rst_req1_ready", 32'(s_r1), 32'd0);
        chk("rst_res_valid", 32'(s_rv), 32'd0);
        chk("rst_res_sum", 32'(s_sum), 32'd0);
        chk("rst_res_id", 32'(s_id), 32'd0);
        chk("rst_busy", 32'(s_busy), 32'd0);
        rst_n = 1'b1;
        wait_accept(1'b0);
        wait_result("both_r0", 1'b0, 17'h02345);
        wait_accept(1'b1);
        wait_result("both_r1", 1'b1, 17'h01000);

        // Vector table: latency, sum and id per entry.
        for (int i = 0; i < 6; i++) begin
            res_ready = 1'b1;
            if (tv[i].id) begin
                req1_valid = 1'b1; req1_a = tv[i].a; req1_b = tv[i].b;
            end else begin
                req0_valid = 1'b1; req0_a = tv[i].a; req0_b = tv[i].b;
            end
            wait_accept(tv[i].id);
            got = 1'b0;
            lat = 0;
            for (int k = 0; k < 30 && !got; k++) begin
                cycle();
                lat++;
                got = s_rv;
            end
            chk("vec_latency", 32'(lat), 32'(NIB + 1));
            chk("vec_sum", 32'(s_sum), 32'(tv[i].sum));
            chk("vec_id", 32'(s_id), 32'(tv[i].id));
        end

        // Result back-pressure for 10 cycles with a competing request waiting.
        res_ready  = 1'b0;
        req0_valid = 1'b1; req0_a = 16'h7777; req0_b = 16'h9999;
        wait_accept(1'b0);
        req1_valid = 1'b1; req1_a = 16'h0102; req1_b = 16'h0304;
        got = 1'b0;
        for (int k = 0; k < 30 && !got; k++) begin
            cycle();
            got = s_rv;
        end
        chk("stall_seen", 32'(got), 32'd1);
        held = {1'b0, 16'h7777} + {1'b0, 16'h9999};
        for (int k = 0; k < 10; k++) begin
            cycle();
            chk("stall_sum", 32'(s_sum), 32'(held));
            chk("stall_id", 32'(s_id), 32'd0);
            chk("stall_r1", 32'(s_r1), 32'd0);
        end
        res_ready = 1'b1;
        cycle();
        chk("release_no_accept", 32'(s_r1), 32'd0);
        cycle();
        chk("resume_r1", 32'(s_r1), 32'd1);
        req1_valid = 1'b0;
        wait_result("resume", 1'b1, 17'h00406);

        // Reset during the second ADD cycle, then a request on req1.
        req0_valid = 1'b1; req0_a = 16'h4444; req0_b = 16'h5555;
        wait_accept(1'b0);
        cycle();
        rst_n = 1'b0;
        req1_valid = 1'b1; req1_a = 16'hF00D; req1_b = 16'h0FF3;
        cycle();
        chk("midrst_r1", 32'(s_r1), 32'd0);
        chk("midrst_valid", 32'(s_rv), 32'd0);
        cycle();
        rst_n = 1'b1;
        wait_accept(1'b1);
        wait_result("after_rst", 1'b1, 17'h10000);

        // req0 held valid, req1 valid once: req1 must win the next free slot.
        req0_valid = 1'b1; req0_a = 16'h0001; req0_b = 16'h0002;
        wait_accept(1'b0);
        req0_valid = 1'b1;
        req1_valid = 1'b1; req1_a = 16'h0010; req1_b = 16'h0020;
        got = 1'b0;
        for (int k = 0; k < 30 && !got; k++) begin
            cycle();
            got = s_r0 | s_r1;
        end
        chk("fair_grant_r1", 32'(s_r1), 32'd1);
        req1_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 30 && !got; k++) begin
            cycle();
            got = s_r0 | s_r1;
        end
        chk("fair_next_r0", 32'(s_r0), 32'd1);
        req0_valid = 1'b0;

        // Randomized traffic against the model.
        for (int k = 0; k < 1500; k++) begin
            req0_valid = 1'($urandom_range(0, 1));
            req1_valid = 1'($urandom_range(0, 1));
            req0_a     = WIDTH'($urandom());
            req0_b     = WIDTH'($urandom());
            req1_a     = WIDTH'($urandom());
            req1_b     = WIDTH'($urandom());
            res_ready  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
            else rst_n = 1'b1;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rca_seq_arbiter.md
Name: rca_seq_arbiter

Overview:
Shares one 4-bit ripple-carry slice between two requesters and uses it to perform WIDTH-bit additions, one nibble per cycle, LSB first.
- Round-robin arbitration between requesters; valid/ready handshake on both inputs and on the single result output.
- Sits in front of the adder datapath so wide adds reuse the small slice instead of instantiating a full-width adder.

Parameters:
WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4.
NIB, WIDTH/4, derived; number of slice passes per add (not user-overridable).

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
req0_valid  input  1  requester 0 has an operand pair.
req0_ready  output  1  requester 0 operands accepted this cycle.
req0_a  input  WIDTH  requester 0 operand A.
req0_b  input  WIDTH  requester 0 operand B.
req1_valid  input  1  requester 1 has an operand pair.
req1_ready  output  1  requester 1 operands accepted this cycle.
req1_a  input  WIDTH  requester 1 operand A.
req1_b  input  WIDTH  requester 1 operand B.
res_valid  output  1  result available.
res_ready  input  1  consumer accepts result.
res_sum  output  WIDTH+1  unsigned sum; MSB is the final carry.
res_id  output  1  requester that owns res_sum.
busy  output  1  high in ADD and DONE states.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; res_valid=0, res_sum=0, res_id=0, busy=0; priority pointer=0 (req0 favoured); carry register=0; nibble counter=0. req0_ready and req1_ready are 0 while rst_n is low.
- Handshake rule: a transfer occurs on a rising edge where valid&ready are both 1. valid must not depend on ready.
- IDLE:
  - readyX is combinational and high only for the granted requester.
  - Grant rule: if only one valid, grant it. If both valid, grant the pointer's requester.
  - On transfer: capture A and B into operand shift registers; carry:=0; counter:=0; res_id:=granted id; pointer:=other id; go to ADD.
  - Both readies are 0 outside IDLE.
- ADD, one slice pass per cycle:
  - Slice inputs are A[3:0], B[3:0] and the carry register.
  - The slice is a 4-bit ripple of full adders whose bit-0 carry-in comes from the carry register.
  - Each edge: sum nibble is shifted into the result register from the top. A and B shift right by 4. carry:=slice carry-out. counter++.
  - After pass NIB-1: res_sum:={carry_out, assembled nibbles}; go to DONE.
- DONE:
  - res_valid=1; res_sum and res_id are held stable until res_ready=1.
  - On the res_valid&res_ready edge: res_valid:=0; go to IDLE.
  - No new request is accepted in that same cycle; next accept is earliest one cycle later.
- Latency: accept edge T, then ADD edges T+1..T+NIB. res_valid is visible in the cycle after edge T+NIB (NIB+1 cycles after accept). With res_ready held high, throughput is one add per NIB+2 cycles.
- Arithmetic: unsigned; res_sum = A+B exactly, width WIDTH+1; no overflow is possible.
- Arbitration:
  - The pointer updates only on a transfer.
  - A requester that drops valid before grant loses nothing; no request is queued internally.
  - Operands are sampled only at the transfer edge; input changes afterwards have no effect.
- Reset mid-operation (ADD or DONE): the operation is aborted silently. No res_valid is produced, and the pointer returns to 0.
- res_ready high while res_valid=0 is ignored.

Test Plan:
- req0 only, A=0xFFFF, B=0x0001, res_ready=1 -> res_valid exactly 5 cycles after accept; res_sum=0x10000; res_id=0; busy high 5 cycles.
- req0 and req1 both valid from reset (req0: 0x1234+0x1111, req1: 0x0F0F+0x00F1) -> req0 served first, res_sum=0x02345, res_id=0; then req1, res_sum=0x01000, res_id=1. Readies never both high.
- Max operands on req1, A=B=0xFFFF -> res_sum=0x1FFFE; verifies carry ripples across all 4 nibbles.
- res_ready held low 10 cycles after res_valid -> res_sum and res_id stable, both readies 0 and no new accept; accept resumes one cycle after release.
- rst_n pulsed low during the 2nd ADD cycle, then req1 presented -> no result for the aborted op; readies 0 during reset; next result is correct.
- req0 continuously valid, req1 valid once -> req1 granted on the next IDLE; the pointer alternates fairly.
